// File: rtl/easyaxi_slv_rsp_order.sv
// Slave-side read-response ordering engine: allocates outstanding slots to AR requests and
// issues R bursts so that same-ID responses leave in request order while other IDs may overtake.
module easyaxi_slv_rsp_order #(
    parameter int OST_DEPTH = 4,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 8,
    localparam int PTR_WIDTH = $clog2(OST_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [LEN_WIDTH-1:0] req_len,
    output logic [PTR_WIDTH-1:0] req_slot,
    input  logic                 done_valid,
    input  logic [PTR_WIDTH-1:0] done_slot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_WIDTH-1:0]  rsp_id,
    output logic [PTR_WIDTH-1:0] rsp_slot,
    output logic [LEN_WIDTH-1:0] rsp_beat,
    output logic                 rsp_last,
    output logic [PTR_WIDTH:0]   ost_cnt
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [PTR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [LEN_WIDTH-1:0] BEAT_ONE = 1;

    state_t state, state_nxt;

    logic [OST_DEPTH-1:0]                valid, done;
    logic [OST_DEPTH-1:0][ID_WIDTH-1:0]  id;
    logic [OST_DEPTH-1:0][LEN_WIDTH-1:0] len;
    logic [OST_DEPTH-1:0][OST_DEPTH-1:0] dep;

    logic [PTR_WIDTH-1:0] cur_slot, cur_nxt, free_idx, elig_idx;
    logic [LEN_WIDTH-1:0] beat, beat_nxt;
    logic [OST_DEPTH-1:0] elig, free_mask, same_id;
    logic                 any_elig, alloc, rsp_hs, burst_end, done_ok;

    // Downward scans so the lowest matching index wins.
    always_comb begin
        free_idx = '0;
        elig_idx = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = PTR_WIDTH'(i);
            if (elig[i])   elig_idx = PTR_WIDTH'(i);
        end
    end

    always_comb begin
        elig    = '0;
        same_id = '0;
        for (int i = 0; i < OST_DEPTH; i++) begin
            elig[i]    = valid[i] & done[i] & ~(|dep[i]);
            same_id[i] = valid[i] & (id[i] == req_id);
        end
    end

    assign any_elig  = |elig;
    assign req_ready = ~(&valid);
    assign req_slot  = free_idx;
    assign alloc     = req_valid & req_ready;
    assign done_ok   = done_valid & valid[done_slot] & ~done[done_slot];

    assign rsp_valid = (state == BURST);
    assign rsp_id    = id[cur_slot];
    assign rsp_slot  = cur_slot;
    assign rsp_beat  = beat;
    assign rsp_last  = (state == BURST) && (beat == len[cur_slot]);
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign burst_end = rsp_hs & rsp_last;

    always_comb begin
        free_mask = '0;
        if (burst_end) free_mask[cur_slot] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_slot;
        beat_nxt  = beat;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nxt = BURST;
                    cur_nxt   = elig_idx;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (rsp_hs) begin
                    if (rsp_last) state_nxt = IDLE;
                    else          beat_nxt  = beat + BEAT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_slot <= '0;
            beat     <= '0;
        end else begin
            state    <= state_nxt;
            cur_slot <= cur_nxt;
            beat     <= beat_nxt;
        end
    end

    // Later assignments override: a new slot's dep replaces the generic bit-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= '0;
            done    <= '0;
            id      <= '0;
            len     <= '0;
            dep     <= '0;
            ost_cnt <= '0;
        end else begin
            for (int i = 0; i < OST_DEPTH; i++) dep[i] <= dep[i] & ~free_mask;
            if (burst_end) begin
                valid[cur_slot] <= 1'b0;
                done[cur_slot]  <= 1'b0;
            end
            if (done_ok) done[done_slot] <= 1'b1;
            if (alloc) begin
                valid[free_idx] <= 1'b1;
                done[free_idx]  <= 1'b0;
                id[free_idx]    <= req_id;
                len[free_idx]   <= req_len;
                dep[free_idx]   <= same_id & ~free_mask;
            end
            case ({alloc, burst_end})
                2'b10:   ost_cnt <= ost_cnt + CNT_ONE;
                2'b01:   ost_cnt <= ost_cnt - CNT_ONE;
                default: ost_cnt <= ost_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_easyaxi_slv_rsp_order.sv
// Directed bench for easyaxi_slv_rsp_order: an age-ordered slot model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_easyaxi_slv_rsp_order;

    localparam int D = 4;
    localparam int IW = 2;
    localparam int LW = 8;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_id = '0;
    logic [LW-1:0] req_len = '0;
    logic [PW-1:0] req_slot;
    logic          done_valid = 1'b0;
    logic [PW-1:0] done_slot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [IW-1:0] rsp_id;
    logic [PW-1:0] rsp_slot;
    logic [LW-1:0] rsp_beat;
    logic          rsp_last;
    logic [PW:0]   ost_cnt;

    easyaxi_slv_rsp_order #(.OST_DEPTH(D), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_len(req_len),
        .req_slot(req_slot), .done_valid(done_valid), .done_slot(done_slot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_slot(rsp_slot),
        .rsp_beat(rsp_beat), .rsp_last(rsp_last), .ost_cnt(ost_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each occupied slot remembers its request age; a completed slot may be
    // issued only when no older occupied slot carries the same ID.
    bit m_valid[D];
    bit m_done[D];
    int m_id[D];
    int m_len[D];
    int m_seq[D];
    int m_ctr = 0;
    bit m_busy = 0;
    int m_cur = 0;
    int m_beat = 0;
    bit armed = 0;

    function automatic int m_free();
        for (int i = 0; i < D; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_pick();
        bit ok;
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && m_done[i]) begin
                ok = 1;
                for (int j = 0; j < D; j++)
                    if (j != i && m_valid[j] && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) ok = 0;
                if (ok) return i;
            end
        end
        return -1;
    endfunction

    int fs, el;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                m_valid[i] <= 0;
                m_done[i]  <= 0;
            end
            m_busy <= 0;
            m_beat <= 0;
            armed  <= 1;
        end else begin
            fs = m_free();
            el = m_pick();
            if (req_valid && fs >= 0) begin
                m_valid[fs] <= 1;
                m_done[fs]  <= 0;
                m_id[fs]    <= int'(req_id);
                m_len[fs]   <= int'(req_len);
                m_seq[fs]   <= m_ctr;
                m_ctr       <= m_ctr + 1;
            end
            if (done_valid && m_valid[done_slot] && !m_done[done_slot]) m_done[done_slot] <= 1;
            if (m_busy) begin
                if (rsp_ready && m_beat == m_len[m_cur]) begin
                    m_valid[m_cur] <= 0;
                    m_done[m_cur]  <= 0;
                    m_busy         <= 0;
                end else if (rsp_ready) begin
                    m_beat <= m_beat + 1;
                end
            end else if (el >= 0) begin
                m_busy <= 1;
                m_cur  <= el;
                m_beat <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m.rsp_valid", rsp_valid, m_busy);
            chk("m.rsp_last", rsp_last, m_busy && (m_beat == m_len[m_cur]));
            if (m_busy) begin
                chk("m.rsp_id", rsp_id, m_id[m_cur]);
                chk("m.rsp_slot", rsp_slot, m_cur);
                chk("m.rsp_beat", rsp_beat, m_beat);
            end
            chk("m.req_ready", req_ready, m_free() >= 0);
            if (m_free() >= 0) chk("m.req_slot", req_slot, m_free());
            chk("m.ost_cnt", ost_cnt, m_count());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int id, input int len);
        req_valid = 1'b1;
        req_id    = IW'(id);
        req_len   = LW'(len);
        step();
        req_valid = 1'b0;
    endtask

    task automatic dn(input int slot);
        done_valid = 1'b1;
        done_slot  = PW'(slot);
        step();
        done_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (ost_cnt != 0 && k < budget) begin
            step();
            k++;
        end
        chk("drain", ost_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst_n = 1'b1;
        chk("rst.req_ready", req_ready, 1);
        chk("rst.req_slot", req_slot, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.ost_cnt", ost_cnt, 0);
        step();

        // single one-beat burst
        req(1, 0);
        chk("s1.ost_alloc", ost_cnt, 1);
        dn(0);
        chk("s1.t+1_valid", rsp_valid, 0);
        step();
        chk("s1.t+2_valid", rsp_valid, 1);
        chk("s1.rsp_id", rsp_id, 1);
        chk("s1.rsp_slot", rsp_slot, 0);
        chk("s1.rsp_last", rsp_last, 1);
        step();
        chk("s1.ost_free", ost_cnt, 0);

        // same-ID ordering
        req(2, 1);
        chk("s2.next_slot", req_slot, 1);
        req(2, 0);
        dn(1);
        for (int i = 0; i < 4; i++) begin
            chk("s2.blocked", rsp_valid, 0);
            step();
        end
        dn(0);
        chk("s2.t+1", rsp_valid, 0);
        step();
        chk("s2.b0_slot", rsp_slot, 0);
        chk("s2.b0_beat", rsp_beat, 0);
        chk("s2.b0_last", rsp_last, 0);
        step();
        chk("s2.b1_slot", rsp_slot, 0);
        chk("s2.b1_beat", rsp_beat, 1);
        chk("s2.b1_last", rsp_last, 1);
        step();
        chk("s2.bubble", rsp_valid, 0);
        step();
        chk("s2.c_valid", rsp_valid, 1);
        chk("s2.c_slot", rsp_slot, 1);
        chk("s2.c_last", rsp_last, 1);
        step();
        chk("s2.ost", ost_cnt, 0);

        // cross-ID overtake
        req(0, 0);
        req(3, 2);
        dn(1);
        step();
        chk("s3.slot", rsp_slot, 1);
        chk("s3.id", rsp_id, 3);
        chk("s3.ost2", ost_cnt, 2);
        step();
        step();
        chk("s3.last", rsp_last, 1);
        step();
        chk("s3.ost1", ost_cnt, 1);
        chk("s3.idle", rsp_valid, 0);
        dn(0);
        drain(10);

        // full and backpressure
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_id  = IW'(i);
            req_len = LW'(i == 2);
            step();
        end
        req_id  = 2'd1;
        req_len = 8'd0;
        chk("s4.full_ready", req_ready, 0);
        chk("s4.full_cnt", ost_cnt, 4);
        rsp_ready = 1'b0;
        dn(2);
        chk("s4.held_cnt", ost_cnt, 4);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("s4.hold_valid", rsp_valid, 1);
            chk("s4.hold_slot", rsp_slot, 2);
            chk("s4.hold_beat", rsp_beat, 0);
            if (i < 2) step();
        end
        rsp_ready = 1'b1;
        step();
        chk("s4.b1_beat", rsp_beat, 1);
        chk("s4.b1_last", rsp_last, 1);
        step();
        chk("s4.reuse_ready", req_ready, 1);
        chk("s4.reuse_slot", req_slot, 2);
        chk("s4.reuse_cnt", ost_cnt, 3);
        step();
        req_valid = 1'b0;
        chk("s4.refill", ost_cnt, 4);
        dn(0);
        dn(1);
        dn(3);
        dn(2);
        drain(60);

        // illegal done, done racing allocation, reset mid-burst
        dn(1);
        step();
        chk("s5.ign_cnt", ost_cnt, 0);
        chk("s5.ign_valid", rsp_valid, 0);
        req_valid  = 1'b1;
        req_id     = 2'd0;
        req_len    = 8'd3;
        done_valid = 1'b1;
        done_slot  = 2'd0;
        step();
        req_valid  = 1'b0;
        done_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s5.race_ign", rsp_valid, 0);
        end
        dn(0);
        step();
        chk("s5.b0", rsp_valid, 1);
        step();
        chk("s5.b1", rsp_beat, 1);
        rst_n = 1'b0;
        step();
        chk("s5.rst_valid", rsp_valid, 0);
        chk("s5.rst_cnt", ost_cnt, 0);
        chk("s5.rst_ready", req_ready, 1);
        chk("s5.rst_slot", req_slot, 0);
        rst_n = 1'b1;
        step();
        dn(0);
        step();
        step();
        chk("s5.post_rst", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/easyaxi_slv_rsp_order.md
Name: easyaxi_slv_rsp_order

Overview:
Slave-side read-response ordering engine: the responder counterpart of the master's outstanding-order tracker. It accepts AR-style requests and allocates each one an outstanding slot. The backend completes slots in any order. The block then issues R bursts so that responses sharing an ID leave in request order, while different IDs may overtake each other. It sits between the slave AR decode and the R channel driver.

Parameters:
OST_DEPTH, 4, number of outstanding slots (power of 2, ≥2); PTR_WIDTH = $clog2(OST_DEPTH)
ID_WIDTH, 4, AXI ID width
LEN_WIDTH, 8, AXI burst length field width (beats = len+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  a free slot exists
req_id  in  ID_WIDTH  request ID
req_len  in  LEN_WIDTH  AXI len
req_slot  out  PTR_WIDTH  slot allocated on handshake (lowest free index)
done_valid  in  1  backend completion pulse
done_slot  in  PTR_WIDTH  completed slot
rsp_valid  out  1  R beat valid
rsp_ready  in  1  R beat accepted
rsp_id  out  ID_WIDTH  ID of current burst
rsp_slot  out  PTR_WIDTH  slot of current burst (for data lookup)
rsp_beat  out  LEN_WIDTH  beat index within burst, 0-based
rsp_last  out  1  final beat of burst
ost_cnt  out  PTR_WIDTH+1  number of occupied slots

Behaviour:
- Synchronous active-low reset. All slot state is cleared (valid, done, id, len, dep). FSM goes to IDLE. Outputs reset as follows: rsp_valid=0, rsp_last=0, rsp_beat=0, rsp_id=0, rsp_slot=0, ost_cnt=0. req_ready=1 from the first cycle after reset. Reset mid-burst aborts the burst with no further beats.
- Per-slot state: valid, done, id, len, and an OST_DEPTH-bit dep mask.
- Allocation:
  - req_ready = |~valid, computed from registered state only.
  - req_slot = lowest index with valid=0.
  - On req_valid&req_ready: set valid=1, done=0, latch id and len.
  - dep = mask of valid slots with the same id, excluding any slot being freed in the same cycle.
- Completion:
  - On done_valid with valid[done_slot]=1 and done=0: set done=1.
  - A done on an invalid or already-done slot is ignored with no state change. This includes a done on a slot being allocated in the same cycle.
- Eligibility: a slot is eligible when valid & done & (dep==0).
- FSM IDLE:
  - If any slot is eligible, select the lowest eligible index.
  - Latch it into cur_slot, set beat=0, go to BURST.
  - rsp_valid=0 in IDLE.
- FSM BURST:
  - rsp_valid=1; rsp_id, rsp_slot and rsp_beat come from registers.
  - rsp_last = (beat == len[cur_slot]).
  - Outputs stay stable while rsp_valid & ~rsp_ready, per AXI rules.
  - On handshake and not last: beat+1.
  - On handshake and last: clear valid/done of cur_slot, clear bit cur_slot in every dep mask, go to IDLE.
- Latency:
  - done_valid sampled in cycle t gives rsp_valid at the earliest in cycle t+2.
  - There is exactly one IDLE bubble between consecutive bursts.
  - A freed slot can be reallocated in the cycle after the last-beat handshake.
- ost_cnt: +1 on allocate, -1 on free, unchanged when both happen in the same cycle.
- len=0 gives a single beat with rsp_last=1 on beat 0.
- When full (ost_cnt==OST_DEPTH), req_ready=0 and the request is held off. req_valid has no effect while req_ready=0.
- Same-ID chains are strict FIFO by construction, because every dep mask points only at older slots, so deadlock cannot occur.

Test Plan:
OST_DEPTH=4, ID_WIDTH=2:
- Reset, then idle: req_ready=1, req_slot=0, rsp_valid=0, ost_cnt=0.
- Single request, one-beat burst: req id=1 len=0 → slot 0. done slot0 at cycle t → rsp_valid at t+2 with rsp_id=1, rsp_slot=0, rsp_last=1. After the handshake, ost_cnt=0.
- Same-ID ordering: req A (id=2, len=1) goes to slot 0 and req B (id=2, len=0) to slot 1. done slot1 first, then slot0 five cycles later → no rsp_valid until slot0 is done. Beats then come out as slot0 beat0, slot0 beat1 (last), one idle cycle, slot1 beat0 (last).
- Cross-ID overtake: slot0 id=0 and slot1 id=3; done slot1 only → slot1 burst is issued while slot0 stays pending. ost_cnt goes 2→1.
- Backpressure and full:
  - Fill 4 slots → req_ready=0 and ost_cnt=4.
  - Hold rsp_ready=0 for 3 cycles mid-burst → outputs stay stable.
  - After the last beat of slot 2, the next cycle shows req_ready=1 and req_slot=2.
- Illegal done and reset: a done on a free slot is ignored and its state is unchanged. Assert rst_n=0 during beat 1 of a len=3 burst → the next cycle shows rsp_valid=0, ost_cnt=0 and all slots free.
